ahb_remap_win: RTL
==================

Name: ahb_remap_win

Overview:
- Parametrised AHB-Lite address-remap stage between a CoreAHB slave port and a CoreAHB master port.
- Translates addresses through NWIN match/translate windows.
- Addresses that hit no enabled window get a local two-cycle ERROR response and are never forwarded.
- Captures the faulting address for software, and accepts window enable changes only at bus-idle points.

Parameters:
- NWIN, 4: number of remap windows, 1..8.
- MATCH_BASE, {NWIN{32'h0}}: packed NWIN*32; window i match value in bits [32*i+31:32*i].
- MATCH_MASK, {NWIN{32'hFFE0_0000}}: packed NWIN*32; address bits compared for window i.
- TARGET_BASE, {NWIN{32'h6000_0000}}: packed NWIN*32; replaces the masked bits on a hit.
- WIN_EN_RST, {NWIN{1'b1}}: reset value of the internal window-enable register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_haddr  in  32  slave address.
- s_hsize  in  2 ; s_hburst in 3 ; s_hprot in 4 ; s_hwdata in 32 ; s_hwrite in 1 ; s_hmastlock in 1.
- s_htrans  in  2  slave transfer type.
- s_hready  in  1  bus ready.
- s_hselx  in  1  slave select.
- s_hrdata  out  32 ; s_hresp out 1 ; s_hreadyout out 1.
- m_haddr  out  32 ; m_hsize out 2 ; m_hburst out 3 ; m_hprot out 4 ; m_htrans out 2 ; m_hwdata out 32 ; m_hlock out 1 ; m_hwrite out 1.
- m_hrdata  in  32 ; m_hresp in 1 ; m_hready in 1.
- win_en  in  NWIN  requested window enables.
- win_en_q  out  NWIN  active window enables.
- err_valid  out  1  sticky flag: an unmapped access occurred.
- err_addr  out  32  address of the first unmapped access since the last clear.
- err_clr  in  1  clears err_valid.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Address phase accepted (acc) = s_hselx & s_hready & s_htrans[1].
- Hit for window i: win_en_q[i] & ((s_haddr & MASK_i) == (MATCH_BASE_i & MASK_i)).
  - Lowest-index hitting window wins.
  - hit = any window hit.
- m_haddr:
  - On a hit: (TARGET_BASE_w & MASK_w) | (s_haddr & ~MASK_w).
  - Otherwise: s_haddr unchanged.
  - Purely combinational.
- m_htrans = acc & hit ? s_htrans : 2'b00. Unselected, stalled or unmapped transfers go out as IDLE.
- Other m_* control/data outputs are straight pass-through. m_hlock = s_hmastlock.
- FSM states: IDLE, FWD, ERR1, ERR2.
  - acc & hit -> FWD.
  - acc & !hit -> ERR1.
  - s_hselx & s_hready & no acc -> IDLE.
  - ERR1 -> ERR2 unconditionally.
  - Transitions out of IDLE/FWD/ERR2 are evaluated only when s_hready=1. FWD with s_hready=0 holds.
- Response mux:
  - FWD: s_hreadyout = m_hready, s_hresp = m_hresp, s_hrdata = m_hrdata.
  - ERR1: s_hreadyout = 0, s_hresp = 1, s_hrdata = 0.
  - ERR2: s_hreadyout = 1, s_hresp = 1, s_hrdata = 0.
  - IDLE: s_hreadyout = 1, s_hresp = 0, s_hrdata = 0.
- ERROR is always exactly two cycles (ERR1, ERR2).
- A new address phase presented during ERR2 is accepted and decoded normally. The master may still drive a non-IDLE transfer there.
- Error capture:
  - On acc & !hit with err_valid=0: err_addr <= s_haddr and err_valid <= 1.
  - Later misses while err_valid=1 leave err_addr unchanged.
  - err_clr clears err_valid. If err_clr and a new miss occur in the same cycle, the miss wins: err_valid=1 and err_addr is loaded.
- Window enables:
  - win_en_q <= win_en only in a cycle where state is IDLE (or FWD with s_hready=1) and acc=0.
  - Never updated mid-transfer or during ERR1/ERR2.
- Reset (rst=1 at posedge):
  - state <= IDLE, err_valid <= 0, err_addr <= 0, win_en_q <= WIN_EN_RST.
  - Combinational outputs then follow: s_hreadyout=1, s_hresp=0, m_htrans=0 when not accepting.
  - Reset mid-ERR1 or mid-FWD abandons the transfer with no error recorded.
- Latency: zero added cycles on forwarded transfers. Two cycles for an unmapped access.

Test Plan:
- NWIN=2 config. Window 0: MATCH 0x0000_0000, MASK 0xFFE0_0000, TARGET 0x6000_0000. Window 1: MATCH 0x0020_0000, MASK 0xFFE0_0000, TARGET 0x2000_0000.
  - NONSEQ read 0x0000_1234 -> m_haddr 0x6000_1234, m_htrans=2.
  - NONSEQ read 0x0021_0010 -> m_haddr 0x2001_0010.
  - m_hrdata 0xDEADBEEF returned with zero wait.
- Read 0x1000_0000 (no hit):
  - m_htrans=0.
  - Next cycle: s_hreadyout=0, s_hresp=1.
  - Following cycle: s_hreadyout=1, s_hresp=1.
  - Then err_valid=1, err_addr=0x1000_0000.
- Second miss 0x3000_0000 while err_valid=1 -> err_addr stays 0x1000_0000.
- err_clr pulse together with a miss at 0x4000_0000 -> err_valid=1, err_addr=0x4000_0000.
- win_en=2'b01 driven while a forwarded transfer is held by m_hready=0 for 3 cycles:
  - win_en_q stays 2'b11 until the bus is idle.
  - Afterwards, 0x0021_0000 returns ERROR.
- s_hselx=0 or s_hready=0 with s_htrans=NONSEQ -> m_htrans=0 and no state change.
- Assert rst during ERR1 -> state IDLE, s_hreadyout=1, err_valid=0, win_en_q=WIN_EN_RST.

Source files
------------

// File: rtl/ahb_remap_win.sv
// ahb_remap_win
// AHB-Lite address-remap stage between a CoreAHB slave port and a CoreAHB
// master port. Each address phase is compared against NWIN match windows.
// On a hit, the masked address bits are replaced by the window target and the
// transfer is forwarded with no added latency. On a miss, the transfer is not
// forwarded; instead a local two-cycle ERROR response is returned, and the
// first faulting address is captured for software.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_*                   AHB-Lite slave side (from the upstream master/bus)
//   m_*                   AHB-Lite master side (to the downstream slave)
//   win_en / win_en_q     requested / active window enables; the active set
//                         changes only at bus-idle points
//   err_valid, err_addr   sticky unmapped-access flag and first fault address
//   err_clr               clears err_valid (a same-cycle miss takes priority)
module ahb_remap_win #(
  parameter int                 NWIN        = 4,
  parameter logic [NWIN*32-1:0] MATCH_BASE  = {NWIN{32'h0000_0000}},
  parameter logic [NWIN*32-1:0] MATCH_MASK  = {NWIN{32'hFFE0_0000}},
  parameter logic [NWIN*32-1:0] TARGET_BASE = {NWIN{32'h6000_0000}},
  parameter logic [NWIN-1:0]    WIN_EN_RST  = {NWIN{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     s_haddr,
  input  logic [1:0]      s_hsize,
  input  logic [2:0]      s_hburst,
  input  logic [3:0]      s_hprot,
  input  logic [31:0]     s_hwdata,
  input  logic            s_hwrite,
  input  logic            s_hmastlock,
  input  logic [1:0]      s_htrans,
  input  logic            s_hready,
  input  logic            s_hselx,
  output logic [31:0]     s_hrdata,
  output logic            s_hresp,
  output logic            s_hreadyout,
  output logic [31:0]     m_haddr,
  output logic [1:0]      m_hsize,
  output logic [2:0]      m_hburst,
  output logic [3:0]      m_hprot,
  output logic [1:0]      m_htrans,
  output logic [31:0]     m_hwdata,
  output logic            m_hlock,
  output logic            m_hwrite,
  input  logic [31:0]     m_hrdata,
  input  logic            m_hresp,
  input  logic            m_hready,
  input  logic [NWIN-1:0] win_en,
  output logic [NWIN-1:0] win_en_q,
  output logic            err_valid,
  output logic [31:0]     err_addr,
  input  logic            err_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        acc;
  logic        hit;
  logic        miss;
  logic        win_upd;
  logic [31:0] sel_mask;
  logic [31:0] sel_tgt;

  assign acc  = s_hselx & s_hready & s_htrans[1];
  assign miss = acc & ~hit;

  // Window decode. The loop runs from the highest index downward, so the
  // lowest-index hitting window is assigned last and takes priority.
  always_comb begin
    hit      = 1'b0;
    sel_mask = 32'h0;
    sel_tgt  = 32'h0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (win_en_q[i] &&
          ((s_haddr & MATCH_MASK[32*i +: 32]) ==
           (MATCH_BASE[32*i +: 32] & MATCH_MASK[32*i +: 32]))) begin
        hit      = 1'b1;
        sel_mask = MATCH_MASK[32*i +: 32];
        sel_tgt  = TARGET_BASE[32*i +: 32];
      end
    end
  end

  // Address translation and forwarding. Unmapped transfers are
  // presented downstream as IDLE.
  assign m_haddr  = hit ? ((sel_tgt & sel_mask) | (s_haddr & ~sel_mask)) : s_haddr;
  assign m_htrans = (acc && hit) ? s_htrans : 2'b00;
  assign m_hsize  = s_hsize;
  assign m_hburst = s_hburst;
  assign m_hprot  = s_hprot;
  assign m_hwdata = s_hwdata;
  assign m_hlock  = s_hmastlock;
  assign m_hwrite = s_hwrite;

  // ERR1 always advances. The other states move only when the bus is ready,
  // so a stalled forwarded data phase holds FWD.
  always_comb begin
    state_nxt = state;
    if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (s_hready) begin
      if (acc) state_nxt = hit ? ST_FWD : ST_ERR1;
      else     state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = 32'h0;
    case (state)
      ST_FWD: begin
        s_hreadyout = m_hready;
        s_hresp     = m_hresp;
        s_hrdata    = m_hrdata;
      end
      ST_ERR1: begin
        s_hreadyout = 1'b0;
        s_hresp     = 1'b1;
      end
      ST_ERR2: begin
        s_hreadyout = 1'b1;
        s_hresp     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables may change only when no transfer is in flight and none is
  // being accepted, so a decode never sees a half-applied window set.
  assign win_upd = ~acc & ((state == ST_IDLE) | ((state == ST_FWD) & s_hready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      win_en_q  <= WIN_EN_RST;
    end else begin
      state <= state_nxt;
      if (win_upd) win_en_q <= win_en;
      // A miss arriving with err_clr re-arms capture in the same cycle.
      if (miss && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_addr  <= s_haddr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end
    end
  end

endmodule
